axi_lite_clint: RTL and testbench

//  AXI-lite responder holding a RISC-V machine timer: 64-bit mtime counter, 64-bit mtimecmp, timer IRQ.

---
 rtl/axi_lite_clint.sv | 215 +++++++++++++++++++++
 tb/tb_axi_lite_clint.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_clint.sv
// AXI-lite machine timer: 64-bit mtime, 64-bit mtimecmp and a level timer IRQ.
// Optional CLINT_SHADOW_EN: MTIME_HI reads return mtime[63:32] latched by the last MTIME_LO read.
module axi_lite_clint #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           STRB_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0200_0000,
    parameter int unsigned           PRESCALE   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_WIDTH-1:0] wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic                  timer_irq_o
);
    typedef enum logic {RIdle, RResp} r_state_e;
    typedef enum logic [1:0] {WIdle, WWaitW, WWaitAw, WResp} w_state_e;

    localparam logic [31:0]           PrescMax = 32'(PRESCALE - 1);
    localparam logic [ADDR_WIDTH-1:0] MapEnd   = ADDR_WIDTH'(32'h14);

    r_state_e              r_state_q;
    w_state_e              w_state_q;
    logic                  arready_q, rvalid_q, awready_q, wready_q, bvalid_q, irq_q;
    logic [DATA_WIDTH-1:0] rdata_q, rd_val;
    logic [1:0]            bresp_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q, rd_off, wr_off, wr_addr;
    logic [DATA_WIDTH-1:0] w_data_q, wr_data;
    logic [STRB_WIDTH-1:0] w_strb_q, wr_strb;
    logic                  ar_hs, aw_hs, w_hs, wr_commit, wr_ok, tick, en_q, en_d;
    logic [63:0]           mtime_q, mtime_d, mtime_inc, cmp_q, cmp_d;
    logic [31:0]           presc_q, presc_d;
`ifdef CLINT_SHADOW_EN
    logic [31:0]           shadow_q;
`endif

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
        end
        return res;
    endfunction

    // Register read decode; addr[1:0] are ignored.
    always_comb begin
        rd_off = araddr_i - BASE_ADDR;
        ar_hs  = arvalid_i && arready_q;
        rd_val = '0;
        if (rd_off < MapEnd) begin
            case (rd_off[4:2])
                3'd0:    rd_val = mtime_q[31:0];
`ifdef CLINT_SHADOW_EN
                3'd1:    rd_val = shadow_q;
`else
                3'd1:    rd_val = mtime_q[63:32];
`endif
                3'd2:    rd_val = cmp_q[31:0];
                3'd3:    rd_val = cmp_q[63:32];
                3'd4:    rd_val = {31'b0, en_q};
                default: rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= RIdle;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                RIdle: if (ar_hs) begin
                    rdata_q   <= rd_val;
                    rvalid_q  <= 1'b1;
                    arready_q <= 1'b0;
                    r_state_q <= RResp;
                end
                RResp: if (rready_i) begin
                    rvalid_q  <= 1'b0;
                    arready_q <= 1'b1;
                    r_state_q <= RIdle;
                end
                default: r_state_q <= RIdle;
            endcase
        end
    end

`ifdef CLINT_SHADOW_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= '0;
        end else if (ar_hs && (rd_off < MapEnd) && (rd_off[4:2] == 3'd0)) begin
            shadow_q <= mtime_q[63:32];
        end
    end
`endif

    // A write commits in the cycle its second beat (or both beats together) handshakes.
    always_comb begin
        aw_hs     = awvalid_i && awready_q;
        w_hs      = wvalid_i && wready_q;
        wr_addr   = (w_state_q == WWaitW) ? aw_addr_q : awaddr_i;
        wr_data   = (w_state_q == WWaitAw) ? w_data_q : wdata_i;
        wr_strb   = (w_state_q == WWaitAw) ? w_strb_q : wstrb_i;
        wr_commit = (aw_hs || (w_state_q == WWaitW)) && (w_hs || (w_state_q == WWaitAw));
        wr_off    = wr_addr - BASE_ADDR;
        wr_ok     = wr_off < MapEnd;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= WIdle;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (wr_commit) begin
            w_state_q <= WResp;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_ok ? 2'b00 : 2'b10;
        end else begin
            case (w_state_q)
                WIdle: begin
                    if (aw_hs) begin
                        aw_addr_q <= awaddr_i;
                        awready_q <= 1'b0;
                        w_state_q <= WWaitW;
                    end else if (w_hs) begin
                        w_data_q  <= wdata_i;
                        w_strb_q  <= wstrb_i;
                        wready_q  <= 1'b0;
                        w_state_q <= WWaitAw;
                    end
                end
                WResp: if (bready_i) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    w_state_q <= WIdle;
                end
                default: ;
            endcase
        end
    end

    // A software write to one mtime half overrides the tick there and blocks any carry across.
    always_comb begin
        tick      = en_q && (presc_q == PrescMax);
        mtime_inc = mtime_q + 64'd1;
        mtime_d   = tick ? mtime_inc : mtime_q;
        cmp_d     = cmp_q;
        en_d      = en_q;
        presc_d   = presc_q;
        if (en_q) presc_d = tick ? 32'd0 : presc_q + 32'd1;
        if (wr_commit && wr_ok) begin
            case (wr_off[4:2])
                3'd0: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wr_data, wr_strb)};
                3'd1: mtime_d = {merge(mtime_q[63:32], wr_data, wr_strb), mtime_inc[31:0]};
                3'd2: cmp_d   = {cmp_q[63:32], merge(cmp_q[31:0], wr_data, wr_strb)};
                3'd3: cmp_d   = {merge(cmp_q[63:32], wr_data, wr_strb), cmp_q[31:0]};
                3'd4: if (wr_strb[0]) en_d = wr_data[0];
                default: ;
            endcase
            if (wr_off[4:2] == 3'd1 && !tick) mtime_d[31:0] = mtime_q[31:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q <= '0;
            cmp_q   <= '1;
            en_q    <= 1'b1;
            presc_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            presc_q <= presc_d;
            irq_q   <= mtime_q >= cmp_q;
        end
    end

    assign arready_o   = arready_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign awready_o   = awready_q;
    assign wready_o    = wready_q;
    assign bvalid_o    = bvalid_q;
    assign bresp_o     = bresp_q;
    assign timer_irq_o = irq_q;
endmodule

// File: tb/tb_axi_lite_clint.sv
// Self-checking bench for axi_lite_clint: directed steps plus random traffic vs a timer model.
module tb_axi_lite_clint;
    localparam int unsigned PRESCALE = 1;
    localparam logic [31:0] BASE     = 32'h0200_0000;
    localparam logic [31:0] A_MLO    = BASE;
    localparam logic [31:0] A_MHI    = BASE + 32'h4;
    localparam logic [31:0] A_CLO    = BASE + 32'h8;
    localparam logic [31:0] A_CHI    = BASE + 32'hC;
    localparam logic [31:0] A_CTRL   = BASE + 32'h10;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic        arready_o, rvalid_o, awready_o, wready_o, bvalid_o, timer_irq_o;
    logic [31:0] rdata_o;
    logic [1:0]  bresp_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [63:0] m_time, m_cmp;
    logic        m_en, m_irq;
    int unsigned m_pcnt;
    logic [31:0] m_shadow, m_rexp;
    logic        m_rd = 1'b0, m_wr = 1'b0;
    logic [31:0] m_raddr = '0, m_waddr = '0, m_wdata = '0;
    logic [3:0]  m_wstrb = '0;

    always #5 clk = ~clk;

    axi_lite_clint #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .BASE_ADDR(BASE), .PRESCALE(PRESCALE)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready_o),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready),
        .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready_o),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready_o),
        .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready),
        .timer_irq_o(timer_irq_o)
    );

    function automatic int m_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (off < 32'h14) ? int'(off >> 2) : -1;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] data,
                                            input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (m_idx(a))
            0: return m_time[31:0];
`ifdef CLINT_SHADOW_EN
            1: return m_shadow;
`else
            1: return m_time[63:32];
`endif
            2: return m_cmp[31:0];
            3: return m_cmp[63:32];
            4: return {31'b0, m_en};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_tick();
        return m_en && (m_pcnt == PRESCALE - 1);
    endfunction

    function automatic logic [63:0] m_next_time();
        logic [63:0] t;
        t = m_tick() ? m_time + 64'd1 : m_time;
        if (m_wr && m_idx(m_waddr) == 0)
            t = {m_time[63:32], m_merge(m_time[31:0], m_wdata, m_wstrb)};
        else if (m_wr && m_idx(m_waddr) == 1)
            t = {m_merge(m_time[63:32], m_wdata, m_wstrb), t[31:0]};
        return t;
    endfunction

    function automatic logic [63:0] m_next_cmp();
        if (m_wr && m_idx(m_waddr) == 2)
            return {m_cmp[63:32], m_merge(m_cmp[31:0], m_wdata, m_wstrb)};
        if (m_wr && m_idx(m_waddr) == 3)
            return {m_merge(m_cmp[63:32], m_wdata, m_wstrb), m_cmp[31:0]};
        return m_cmp;
    endfunction

    function automatic logic m_next_en();
        if (m_wr && m_idx(m_waddr) == 4 && m_wstrb[0]) return m_wdata[0];
        return m_en;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_time <= '0; m_cmp <= '1; m_en <= 1'b1; m_pcnt <= 0;
            m_irq <= 1'b0; m_shadow <= '0; m_rexp <= '0;
        end else begin
            m_time <= m_next_time();
            m_cmp  <= m_next_cmp();
            m_en   <= m_next_en();
            m_pcnt <= m_en ? (m_tick() ? 0 : m_pcnt + 1) : m_pcnt;
            m_irq  <= m_time >= m_cmp;
            if (m_rd) begin
                m_rexp <= m_read(m_raddr);
                if (m_idx(m_raddr) == 0) m_shadow <= m_time[63:32];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            check("irq", timer_irq_o, m_irq);
        end
    endtask

    task automatic rd(input logic [31:0] addr, input int rdly, output logic [31:0] data);
        araddr = addr; arvalid = 1'b1; m_raddr = addr; m_rd = 1'b1;
        step();
        arvalid = 1'b0; m_rd = 1'b0;
        check("ar_busy", arready_o, 0);
        check("rvalid", rvalid_o, 1);
        check("rdata", rdata_o, m_rexp);
        repeat (rdly) begin
            step();
            check("rvalid_hold", rvalid_o, 1);
            check("rdata_hold", rdata_o, m_rexp);
        end
        data = rdata_o;
        rready = 1'b1;
        step();
        rready = 1'b0;
        check("rvalid_clr", rvalid_o, 0);
        check("ar_ready", arready_o, 1);
        check("irq", timer_irq_o, m_irq);
    endtask

    // gap > 0: AW leads W by gap cycles; gap < 0: W leads AW.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int gap, input int bdly);
        logic [1:0] exp_resp;
        exp_resp = (m_idx(addr) >= 0) ? 2'b00 : 2'b10;
        if (gap > 0) begin
            awaddr = addr; awvalid = 1'b1;
            step();
            awvalid = 1'b0;
            check("aw_busy", awready_o, 0);
            repeat (gap - 1) begin step(); check("aw_busy", awready_o, 0); end
            wdata = data; wstrb = strb; wvalid = 1'b1;
        end else if (gap < 0) begin
            wdata = data; wstrb = strb; wvalid = 1'b1;
            step();
            wvalid = 1'b0;
            check("w_busy", wready_o, 0);
            repeat (-gap - 1) begin step(); check("w_busy", wready_o, 0); end
            awaddr = addr; awvalid = 1'b1;
        end else begin
            awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
        end
        m_waddr = addr; m_wdata = data; m_wstrb = strb; m_wr = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; m_wr = 1'b0;
        check("bvalid", bvalid_o, 1);
        check("bresp", bresp_o, exp_resp);
        repeat (bdly) begin
            step();
            check("bvalid_hold", bvalid_o, 1);
            check("bresp_hold", bresp_o, exp_resp);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("bvalid_clr", bvalid_o, 0);
        check("aw_ready", awready_o, 1);
        check("w_ready", wready_o, 1);
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        logic [31:0] lo;
        k = int'($urandom_range(0, 10));
        lo = $urandom_range(0, 3);
        if (k < 8) return BASE + 32'(k * 4) + lo;
        if (k == 8) return BASE - 32'h4 + lo;
        if (k == 9) return BASE + 32'h20 + lo;
        return $urandom;
    endfunction

    initial begin
        logic [31:0] d, a;
        step();
        step();
        check("rst_arready", arready_o, 1);
        check("rst_awready", awready_o, 1);
        check("rst_wready", wready_o, 1);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_bvalid", bvalid_o, 0);
        check("rst_bresp", bresp_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_irq", timer_irq_o, 0);
        rst = 1'b0;

        // Free-running count after reset
        idle(10);
        rd(A_MLO, 0, d);
        check("t1_mtime_range", (d >= 32'd10 && d <= 32'd12), 1);
        check("t1_irq", timer_irq_o, 0);

        // Compare hit and clear
        wr(A_CHI, 32'h0, 4'hF, 0, 0);
        wr(A_MLO, 32'h0, 4'hF, 0, 0);
        wr(A_CLO, 32'd20, 4'hF, 0, 0);
        idle(30);
        check("t2_irq_set", timer_irq_o, 1);
        wr(A_CLO, 32'hFFFF_FFFF, 4'hF, 0, 0);
        idle(2);
        check("t2_irq_clr", timer_irq_o, 0);

        // Split AW/W beats and response backpressure
        wr(A_CHI, 32'h0, 4'hF, 3, 5);
        wr(A_CHI, 32'h0, 4'hF, -2, 1);

        // Unmapped offset
        rd(BASE + 32'h18, 1, d);
        check("t4_unmapped_rd", d, 32'h0);
        wr(BASE + 32'h18, 32'h1234_5678, 4'hF, 0, 0);
        rd(A_MLO, 0, d);
        rd(A_MHI, 0, d);
        rd(A_CLO, 0, d);
        check("t4_cmp_lo_kept", d, 32'hFFFF_FFFF);
        rd(A_CHI, 0, d);
        rd(A_CTRL, 0, d);
        check("t4_ctrl_kept", d, 32'h1);

        // Low-word wrap carries into the high word
        wr(A_CTRL, 32'h0, 4'hF, 0, 0);
        wr(A_MLO, 32'hFFFF_FFFF, 4'hF, 0, 0);
        wr(A_MHI, 32'h0, 4'hF, 0, 0);
        wr(A_CTRL, 32'h1, 4'hF, 0, 0);
        idle(3);
        rd(A_MHI, 0, d);
        check("t5_carry_hi", d, 32'h1);
        rd(A_MLO, 0, d);

        // LO read before the wrap, HI read after it
        wr(A_CTRL, 32'h0, 4'hF, 0, 0);
        wr(A_MLO, 32'hFFFF_FFF0, 4'hF, 0, 0);
        wr(A_MHI, 32'h0, 4'hF, 0, 0);
        wr(A_CTRL, 32'h1, 4'hF, 0, 0);
        rd(A_MLO, 0, d);
        idle(30);
        rd(A_MHI, 0, d);
`ifdef CLINT_SHADOW_EN
        check("t5_shadow_hi", d, 32'h0);
`else
        check("t5_live_hi", d, 32'h1);
`endif

        // Byte strobes
        wr(A_CLO, 32'hFFFF_FFFF, 4'hF, 0, 0);
        wr(A_CLO, 32'hAABB_CCDD, 4'b0010, 1, 0);
        rd(A_CLO, 0, d);
        check("t6_strb", d, 32'hFFFF_CCFF);

        // Same-cycle read and write of one register sees the old value
        araddr = A_CLO; arvalid = 1'b1; m_raddr = A_CLO; m_rd = 1'b1;
        awaddr = A_CLO; awvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        m_waddr = A_CLO; m_wdata = 32'h1234_5678; m_wstrb = 4'hF; m_wr = 1'b1;
        step();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
        check("rw_rvalid", rvalid_o, 1);
        check("rw_rdata_old", rdata_o, 32'hFFFF_CCFF);
        check("rw_bvalid", bvalid_o, 1);
        rready = 1'b1; bready = 1'b1;
        step();
        rready = 1'b0; bready = 1'b0;
        rd(A_CLO, 0, d);
        check("rw_new", d, 32'h1234_5678);

        // Reset while a read response is pending
        araddr = A_MLO; arvalid = 1'b1; m_raddr = A_MLO; m_rd = 1'b1;
        step();
        arvalid = 1'b0; m_rd = 1'b0;
        check("rr_rvalid", rvalid_o, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rr_rvalid_drop", rvalid_o, 0);
        check("rr_arready", arready_o, 1);
        check("rr_rdata", rdata_o, 0);
        check("rr_irq", timer_irq_o, 0);
        rd(A_MHI, 0, d);
        check("rr_mhi", d, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 150; i++) begin
            a = rand_addr();
            if ($urandom_range(0, 1) == 1) begin
                rd(a, int'($urandom_range(0, 2)), d);
            end else begin
                wr(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                   int'($urandom_range(0, 3)));
            end
            idle(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
